// File: rtl/drain_pkg.sv
// rtl/drain_pkg.sv - shared types and constants for the result_drain block
// Contents: FSM state enum, default array geometry, index width, saturation bounds.
package drain_pkg;

    localparam int DEF_ROWS      = 4;
    localparam int DEF_COLS      = 4;
    localparam int DEF_ACC_WIDTH = 20;
    localparam int DEF_OUT_WIDTH = 16;

    // Width of the row-major word index over the whole array.
    localparam int IDX_W = $clog2(DEF_ROWS * DEF_COLS);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    // Signed range of an out_width-bit result word (valid for out_width <= 31).
    function automatic int sat_max(input int out_width);
        return (1 << (out_width - 1)) - 1;
    endfunction

    function automatic int sat_min(input int out_width);
        return -(1 << (out_width - 1));
    endfunction

endpackage

// File: rtl/result_sat.sv
// rtl/result_sat.sv - truncate or signed-saturate one accumulator word to the output width
// Ports: word (ACC_WIDTH in), data (OUT_WIDTH out), clip (out, only with RESULT_DRAIN_SAT_EN).
// Macro: RESULT_DRAIN_SAT_EN selects saturation; otherwise the low bits are passed through.
module result_sat
    import drain_pkg::*;
#(
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic [ACC_WIDTH-1:0] word,
`ifdef RESULT_DRAIN_SAT_EN
    output logic                 clip,
`endif
    output logic [OUT_WIDTH-1:0] data
);

    generate
        if (OUT_WIDTH == ACC_WIDTH) begin : g_pass
            assign data = word;
`ifdef RESULT_DRAIN_SAT_EN
            assign clip = 1'b0;
`endif
        end else begin : g_narrow
`ifdef RESULT_DRAIN_SAT_EN
            localparam logic signed [ACC_WIDTH-1:0] MAX_W = ACC_WIDTH'(sat_max(OUT_WIDTH));
            localparam logic signed [ACC_WIDTH-1:0] MIN_W = ACC_WIDTH'(sat_min(OUT_WIDTH));

            always_comb begin
                data = word[OUT_WIDTH-1:0];
                clip = 1'b0;
                if ($signed(word) > MAX_W) begin
                    data = MAX_W[OUT_WIDTH-1:0];
                    clip = 1'b1;
                end else if ($signed(word) < MIN_W) begin
                    data = MIN_W[OUT_WIDTH-1:0];
                    clip = 1'b1;
                end
            end
`else
            // Upper accumulator bits are intentionally discarded.
            logic unused_hi;
            assign unused_hi = ^word[ACC_WIDTH-1:OUT_WIDTH];
            assign data      = word[OUT_WIDTH-1:0];
`endif
        end
    endgenerate

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - snapshot the systolic array accumulators and stream them out row-major
// Ports: clk, rst (sync, active-high), done_in, acc_in (flattened PE accumulators), acc_clear,
//        busy, out_valid/out_ready/out_data/out_row/out_col/out_last stream, overrun (sticky),
//        sat_flag (only with RESULT_DRAIN_SAT_EN).
// Macro: RESULT_DRAIN_SAT_EN enables signed saturation of out_data and the sat_flag port.
module result_drain
    import drain_pkg::*;
#(
    parameter int ROWS      = DEF_ROWS,
    parameter int COLS      = DEF_COLS,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int OUT_WIDTH = DEF_OUT_WIDTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          done_in,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0] acc_in,
    output logic                          acc_clear,
    output logic                          busy,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [OUT_WIDTH-1:0]          out_data,
    output logic [$clog2(ROWS)-1:0]       out_row,
    output logic [$clog2(COLS)-1:0]       out_col,
    output logic                          out_last,
`ifdef RESULT_DRAIN_SAT_EN
    output logic                          sat_flag,
`endif
    output logic                          overrun
);

    localparam int N     = ROWS * COLS;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    state_t               state;
    state_t               state_nxt;
    logic [IDX_W-1:0]     idx;
    logic [ACC_WIDTH-1:0] snap [N];
    logic                 xfer;
    logic                 at_last;
    logic                 accept;
    logic [OUT_WIDTH-1:0] word_out;
`ifdef RESULT_DRAIN_SAT_EN
    logic                 word_clip;
`endif

    assign at_last = (idx == LAST_IDX);
    assign xfer    = out_valid && out_ready;
    // A new snapshot is taken from IDLE, or exactly on the final transfer so
    // back-to-back results stream without an idle gap.
    assign accept  = done_in && ((state == IDLE) || (xfer && at_last));

    result_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .word (snap[idx]),
`ifdef RESULT_DRAIN_SAT_EN
        .clip (word_clip),
`endif
        .data (word_out)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (done_in) state_nxt = STREAM;
            STREAM:  if (xfer && at_last && !done_in) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        out_valid = (state == STREAM);
        busy      = (state == STREAM);
        out_last  = out_valid && at_last;
        out_data  = out_valid ? word_out : '0;
        out_row   = ROW_W'(32'(idx) / COLS);
        out_col   = COL_W'(32'(idx) % COLS);
`ifdef RESULT_DRAIN_SAT_EN
        sat_flag  = out_valid && word_clip;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            acc_clear <= 1'b0;
            overrun   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                snap[i] <= '0;
            end
        end else begin
            acc_clear <= accept;
            if (accept) begin
                idx <= '0;
                for (int i = 0; i < N; i++) begin
                    snap[i] <= acc_in[i*ACC_WIDTH +: ACC_WIDTH];
                end
            end else if (xfer) begin
                idx <= at_last ? '0 : idx + 1'b1;
            end
            if (done_in && !accept) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - scoreboard bench for result_drain
// Macro: RESULT_DRAIN_SAT_EN switches the expected-value model to saturation.
module tb_result_drain;

    localparam int NW = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         done_in;
    logic [319:0] acc_in;
    logic         acc_clear;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_row;
    logic [1:0]   out_col;
    logic         out_last;
    logic         overrun;
`ifdef RESULT_DRAIN_SAT_EN
    logic         sat_flag;
`endif

    always #5 clk = ~clk;

    result_drain dut (
        .clk       (clk),
        .rst       (rst),
        .done_in   (done_in),
        .acc_in    (acc_in),
        .acc_clear (acc_clear),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_row   (out_row),
        .out_col   (out_col),
        .out_last  (out_last),
`ifdef RESULT_DRAIN_SAT_EN
        .sat_flag  (sat_flag),
`endif
        .overrun   (overrun)
    );

    typedef struct packed {
        logic [15:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
        logic        flag;
    } exp_t;

    exp_t               sb[$];
    int                 n_checks = 0;
    int                 n_errors = 0;
    logic signed [19:0] acc_m [NW];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input int i, input logic signed [19:0] v);
        exp_t e;
        int   sv;
        sv     = v;
        e.row  = 2'(i / 4);
        e.col  = 2'(i % 4);
        e.last = (i == NW - 1);
        e.flag = 1'b0;
        e.data = v[15:0];
`ifdef RESULT_DRAIN_SAT_EN
        if (sv > 32767) begin
            e.data = 16'h7FFF;
            e.flag = 1'b1;
        end else if (sv < -32768) begin
            e.data = 16'h8000;
            e.flag = 1'b1;
        end
`endif
        return e;
    endfunction

    task automatic load_acc();
        for (int i = 0; i < NW; i++) acc_in[i*20 +: 20] = acc_m[i];
    endtask

    task automatic scramble_acc();
        for (int i = 0; i < 10; i++) acc_in[i*32 +: 32] = $urandom();
    endtask

    // Raise done_in for one edge; push the expected stream when it should be accepted.
    task automatic fire_done(input bit expect_accept);
        done_in = 1'b1;
        if (expect_accept) begin
            for (int i = 0; i < NW; i++) sb.push_back(model(i, acc_m[i]));
        end
        @(posedge clk);
        #1;
        done_in = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int k = 0;
        while ((busy || sb.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drained"}, 32'(k < 300), 32'd1);
    endtask

    task automatic wait_word(input string tag, input int r, input int c);
        int k = 0;
        @(negedge clk);
        while (!(out_valid && out_row == 2'(r) && out_col == 2'(c)) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_reached"}, 32'(k < 200), 32'd1);
    endtask

    // Ready pattern 1,0,0 repeating when enabled.
    int ready_mode = 0;
    int rcnt       = 0;
    always @(posedge clk) begin
        #1;
        if (ready_mode != 0) begin
            out_ready = (rcnt % 3 == 0);
            rcnt++;
        end
    end

    // Scoreboard consumer plus stall-stability monitor.
    exp_t        e;
    logic        stall_prev = 1'b0;
    logic [15:0] d_prev;
    logic [1:0]  r_prev, c_prev;
    logic        l_prev;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check("valid_hold", out_valid, 1'b1);
                check("hold_data", out_data, d_prev);
                check("hold_rowcol", {out_row, out_col}, {r_prev, c_prev});
                check("hold_last", out_last, l_prev);
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    e = sb.pop_front();
                    check("data", out_data, e.data);
                    check("row", out_row, e.row);
                    check("col", out_col, e.col);
                    check("last", out_last, e.last);
`ifdef RESULT_DRAIN_SAT_EN
                    check("sat_flag", sat_flag, e.flag);
`endif
                end
            end
            stall_prev = out_valid && !out_ready;
            d_prev     = out_data;
            r_prev     = out_row;
            c_prev     = out_col;
            l_prev     = out_last;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        done_in   = 1'b0;
        out_ready = 1'b0;
        acc_in    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_clear", acc_clear, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_data", out_data, 16'h0);
        check("rst_last", out_last, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 1: straight stream, full throughput; acc_in changes after capture are ignored
        for (int i = 0; i < NW; i++) acc_m[i] = 20'(i);
        load_acc();
        out_ready = 1'b1;
        fire_done(1'b1);
        scramble_acc();
        check("t1_clear_t1", acc_clear, 1'b1);
        check("t1_valid_t1", out_valid, 1'b1);
        check("t1_busy_t1", busy, 1'b1);
        @(posedge clk);
        #1;
        check("t1_clear_t2", acc_clear, 1'b0);
        repeat (14) @(posedge clk);
        #1;
        check("t1_last_w15", out_last, 1'b1);
        check("t1_busy_w15", busy, 1'b1);
        @(posedge clk);
        #1;
        check("t1_busy_end", busy, 1'b0);
        check("t1_valid_end", out_valid, 1'b0);
        check("t1_sb_empty", sb.size(), 0);

        // 2: throttled sink
        load_acc();
        for (int i = 0; i < NW; i++) acc_m[i] = 20'(i);
        load_acc();
        ready_mode = 1;
        fire_done(1'b1);
        wait_drain("t2");
        ready_mode = 0;
        out_ready  = 1'b1;
        @(posedge clk);
        #1;

        // 3: back-to-back snapshot on the final transfer
        fire_done(1'b1);
        wait_word("t3", 3, 3);
        for (int i = 0; i < NW; i++) acc_m[i] = 20'(100 + i);
        load_acc();
        fire_done(1'b1);
        check("t3_clear", acc_clear, 1'b1);
        check("t3_valid", out_valid, 1'b1);
        check("t3_data0", out_data, 16'd100);
        check("t3_overrun", overrun, 1'b0);
        wait_drain("t3");
        check("t3_overrun_end", overrun, 1'b0);

        // 4: done_in mid-stream is dropped and flagged
        for (int i = 0; i < NW; i++) acc_m[i] = 20'(3 * i - 20);
        load_acc();
        fire_done(1'b1);
        wait_word("t4", 1, 1);
        scramble_acc();
        fire_done(1'b0);
        check("t4_clear", acc_clear, 1'b0);
        check("t4_overrun", overrun, 1'b1);
        wait_drain("t4");
        check("t4_overrun_sticky", overrun, 1'b1);

        // 5: reset mid-stream at idx 7
        for (int i = 0; i < NW; i++) acc_m[i] = 20'(50 * i + 7);
        load_acc();
        fire_done(1'b1);
        wait_word("t5", 1, 2);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        rst       = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        check("t5_valid", out_valid, 1'b0);
        check("t5_busy", busy, 1'b0);
        check("t5_overrun", overrun, 1'b0);
        check("t5_data", out_data, 16'h0);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t5_idle_after", out_valid, 1'b0);
        fire_done(1'b1);
        check("t5_restart_data", out_data, 16'd7);
        wait_drain("t5");

        // 6: width handling at the range extremes
        for (int i = 0; i < NW; i++) acc_m[i] = 20'(i);
        acc_m[0] = 20'(40000);
        acc_m[1] = -20'sd40000;
        acc_m[2] = 20'(1234);
        load_acc();
        fire_done(1'b1);
`ifdef RESULT_DRAIN_SAT_EN
        check("t6_word0", out_data, 16'h7FFF);
        check("t6_flag0", sat_flag, 1'b1);
`else
        check("t6_word0", out_data, 16'h9C40);
`endif
        wait_drain("t6");

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
